// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard control for the 5-stage RV32 pipeline.
// Handles operand forwarding, load-use stalls, branch flushes, a multi-cycle
// mul/div start/done handshake, data-memory wait-state freezes, and
// saturating performance counters.
//
// Ports:
//   i_clk, i_reset          pipeline clock, asynchronous active-high reset
//   i_Rs1D/i_Rs2D           source registers in Decode
//   i_Rs1E/i_Rs2E           source registers in Execute
//   i_RdE/i_RdM/i_RdW       destination registers in Execute/Memory/Writeback
//   i_RegWrite{E,M,W}       register-write enables per stage
//   i_ResultSrcE0           Execute instruction is a load
//   i_PCSrcE                taken branch/jump resolved in Execute
//   i_MulDivE, i_MdDoneE    mul/div in Execute, mul/div result valid
//   i_DmemReadyM            data memory access complete
//   o_ForwardAE/BE          00 regfile, 01 Writeback, 10 Memory ALU result
//   o_Stall{F,D,E,M}        hold pipeline registers
//   o_Flush{D,E,M,W}        clear pipeline registers
//   o_MdStart, o_MdTimeout  mul/div start pulse, sticky timeout flag
//   o_*Cnt                  saturating event counters
//
// State | meaning
// MD_IDLE | no mul/div outstanding
// MD_BUSY | mul/div issued, Execute held until done or timeout
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [REG_AW-1:0] i_Rs1D,
  input  logic [REG_AW-1:0] i_Rs2D,
  input  logic [REG_AW-1:0] i_Rs1E,
  input  logic [REG_AW-1:0] i_Rs2E,
  input  logic [REG_AW-1:0] i_RdE,
  input  logic [REG_AW-1:0] i_RdM,
  input  logic [REG_AW-1:0] i_RdW,
  input  logic              i_RegWriteE,
  input  logic              i_RegWriteM,
  input  logic              i_RegWriteW,
  input  logic              i_ResultSrcE0,
  input  logic              i_PCSrcE,
  input  logic              i_MulDivE,
  input  logic              i_MdDoneE,
  input  logic              i_DmemReadyM,
  output logic [1:0]        o_ForwardAE,
  output logic [1:0]        o_ForwardBE,
  output logic              o_StallF,
  output logic              o_StallD,
  output logic              o_StallE,
  output logic              o_StallM,
  output logic              o_FlushD,
  output logic              o_FlushE,
  output logic              o_FlushM,
  output logic              o_FlushW,
  output logic              o_MdStart,
  output logic              o_MdTimeout,
  output logic [CNT_W-1:0]  o_LoadStallCnt,
  output logic [CNT_W-1:0]  o_MdStallCnt,
  output logic [CNT_W-1:0]  o_MemStallCnt,
  output logic [CNT_W-1:0]  o_FlushCnt
);

  localparam int BW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam bit TO_EN = (MD_TIMEOUT != 0);
  localparam logic [BW-1:0] TO_LAST = TO_EN ? BW'(MD_TIMEOUT - 1) : '0;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t        r_state;
  logic [BW-1:0]    r_busy_cnt;
  logic             r_md_timeout;
  logic [CNT_W-1:0] r_load_cnt, r_md_cnt, r_mem_cnt, r_flush_cnt;

  logic w_mem_stall, w_md_issue, w_md_done_ok, w_md_to_fire, w_md_stall;
  logic w_lw_raw, w_lw_stall, w_branch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    w_mem_stall  = ~i_DmemReadyM;
    w_md_issue   = (r_state == MD_IDLE) & i_MulDivE & ~w_mem_stall;
    w_md_done_ok = (r_state == MD_BUSY) & i_MdDoneE & ~w_mem_stall;
    // Timeout only fires on a cycle the memory is not freezing everything,
    // so a pending wait state simply defers it.
    w_md_to_fire = TO_EN & (r_state == MD_BUSY) & ~i_MdDoneE & ~w_mem_stall &
                   (r_busy_cnt == TO_LAST);
    w_md_stall   = (r_state == MD_IDLE) ? w_md_issue : ~(w_md_done_ok | w_md_to_fire);

    w_lw_raw   = i_ResultSrcE0 & (i_RdE != '0) & ((i_Rs1D == i_RdE) | (i_Rs2D == i_RdE));
    w_lw_stall = w_lw_raw & ~w_mem_stall & ~w_md_stall;
    w_branch   = i_PCSrcE & ~w_mem_stall;

    if (i_RegWriteM && (i_Rs1E != '0) && (i_Rs1E == i_RdM))      o_ForwardAE = 2'b10;
    else if (i_RegWriteW && (i_Rs1E != '0) && (i_Rs1E == i_RdW)) o_ForwardAE = 2'b01;
    else                                                          o_ForwardAE = 2'b00;

    if (i_RegWriteM && (i_Rs2E != '0) && (i_Rs2E == i_RdM))      o_ForwardBE = 2'b10;
    else if (i_RegWriteW && (i_Rs2E != '0) && (i_Rs2E == i_RdW)) o_ForwardBE = 2'b01;
    else                                                          o_ForwardBE = 2'b00;

    // Fetch redirect from a taken branch beats a load-use hold on F/D.
    o_StallF = w_mem_stall | w_md_stall | (w_lw_stall & ~w_branch);
    o_StallD = w_mem_stall | w_md_stall | (w_lw_stall & ~w_branch);
    o_StallE = w_mem_stall | w_md_stall;
    o_StallM = w_mem_stall;
    o_FlushD = w_branch;
    o_FlushE = w_lw_stall | w_branch;
    o_FlushM = w_md_stall & ~w_mem_stall;
    o_FlushW = w_mem_stall;
    o_MdStart = w_md_issue & ~i_reset;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= MD_IDLE;
      r_busy_cnt   <= '0;
      r_md_timeout <= 1'b0;
      r_load_cnt   <= '0;
      r_md_cnt     <= '0;
      r_mem_cnt    <= '0;
      r_flush_cnt  <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_md_issue) begin
            r_state    <= MD_BUSY;
            r_busy_cnt <= '0;
          end
        end
        MD_BUSY: begin
          if (w_md_done_ok || w_md_to_fire) begin
            r_state <= MD_IDLE;
            if (w_md_to_fire) r_md_timeout <= 1'b1;
          end else if (r_busy_cnt != TO_LAST) begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
      r_load_cnt  <= sat_inc(r_load_cnt, w_lw_stall);
      r_md_cnt    <= sat_inc(r_md_cnt, w_md_stall);
      r_mem_cnt   <= sat_inc(r_mem_cnt, w_mem_stall);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_branch);
    end
  end

  assign o_MdTimeout    = r_md_timeout;
  assign o_LoadStallCnt = r_load_cnt;
  assign o_MdStallCnt   = r_md_cnt;
  assign o_MemStallCnt  = r_mem_cnt;
  assign o_FlushCnt     = r_flush_cnt;

endmodule
